// File: rtl/xintf_ram_arbiter.sv
// xintf_ram_arbiter
//   Shares a single XINTF DPBRAM port between N_REQ burst requesters.
//   Arbitration is round-robin. A burst keeps the grant while its request
//   stays high. When another requester is waiting, a hold limit ends the
//   burst after MAX_HOLD accesses. Each read is tagged with its requester
//   and the read data is returned to that requester.
//
// Ports
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_req / i_we     per-requester burst request and write select
//   i_addr / i_din   packed per-requester address and write data
//                    (requester k at [k*W +: W])
//   o_gnt            registered one-hot grant
//   o_ram_*          DPBRAM address, data, enable and write enable
//   i_ram_dout       DPBRAM read data, RD_LAT cycles after o_ram_ce
//   o_rd_data        registered read return data
//   o_rd_valid       one-hot read return strobe to the issuing requester
//   o_owner          index of the current or last granted requester
//   o_busy           high whenever the arbiter is not idle
module xintf_ram_arbiter #(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_we,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_din,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [ADDR_W-1:0]         o_ram_addr,
  output logic [DATA_W-1:0]         o_ram_din,
  output logic                      o_ram_ce,
  output logic                      o_ram_we,
  input  logic [DATA_W-1:0]         i_ram_dout,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic [N_REQ-1:0]          o_rd_valid,
  output logic [1:0]                o_owner,
  output logic                      o_busy
);

  localparam int         CNT_W   = $clog2(MAX_HOLD + 1);
  localparam logic [1:0] RR_INIT = 2'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic [1:0]         owner_nxt;
  logic [1:0]         rr, rr_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic               accept;
  logic               req_own;
  logic               others;
  logic [1:0]         win;
  logic               win_found;
  logic [2:0]         idx;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_din;
  logic [1:0]         ram_tag;

  // Read tag pipe: stage s is valid s+1 cycles after the o_ram_ce cycle.
  logic               rd_vld_p [RD_LAT];
  logic [1:0]         rd_tag_p [RD_LAT];

  // The hold count stops at MAX_HOLD, so a lone requester can keep the
  // grant for as long as it wants.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_W'(MAX_HOLD)) return v;
    return v + CNT_W'(1);
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input logic [1:0] k);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int j = 0; j < N_REQ; j++)
      if (k == 2'(j)) v[j] = 1'b1;
    return v;
  endfunction

  assign req_own = |(i_req & o_gnt);
  assign others  = |(i_req & ~o_gnt);
  assign o_busy  = (state != IDLE);

  // Round-robin search. Start at rr+1 and wrap around. rr itself is
  // checked last.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = {1'b0, rr} + 3'(i);
      if (idx >= 3'(N_REQ)) idx = idx - 3'(N_REQ);
      for (int j = 0; j < N_REQ; j++)
        if (!win_found && idx == 3'(j) && i_req[j]) begin
          win       = 2'(j);
          win_found = 1'b1;
        end
    end
  end

  // Take the access fields from the granted requester. o_gnt is one-hot
  // or zero.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int j = 0; j < N_REQ; j++)
      if (o_gnt[j]) begin
        sel_we   = i_we[j];
        sel_addr = i_addr[j*ADDR_W +: ADDR_W];
        sel_din  = i_din[j*DATA_W +: DATA_W];
      end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = o_gnt;
    owner_nxt    = o_owner;
    rr_nxt       = rr;
    hold_cnt_nxt = hold_cnt;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt    = GRANT;
          gnt_nxt      = to_onehot(win);
          owner_nxt    = win;
          rr_nxt       = win;
          hold_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!req_own) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
        end else begin
          accept       = 1'b1;
          hold_cnt_nxt = sat_inc(hold_cnt);
          if (hold_cnt_nxt == CNT_W'(MAX_HOLD) && others) begin
            state_nxt = RELEASE;
            gnt_nxt   = '0;
          end
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      o_gnt    <= '0;
      o_owner  <= '0;
      rr       <= RR_INIT;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      o_gnt    <= gnt_nxt;
      o_owner  <= owner_nxt;
      rr       <= rr_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // RAM command stage: one access for each accepted grant cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ram_ce   <= 1'b0;
      o_ram_we   <= 1'b0;
      o_ram_addr <= '0;
      o_ram_din  <= '0;
      ram_tag    <= '0;
    end else begin
      o_ram_ce <= accept;
      o_ram_we <= accept & sel_we;
      if (accept) begin
        o_ram_addr <= sel_addr;
        o_ram_din  <= sel_din;
        ram_tag    <= o_owner;
      end
    end
  end

  // Read tag pipe: the tag travels while the DPBRAM produces the data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        rd_vld_p[s] <= 1'b0;
        rd_tag_p[s] <= '0;
      end
    end else begin
      rd_vld_p[0] <= o_ram_ce & ~o_ram_we;
      rd_tag_p[0] <= ram_tag;
      for (int s = 1; s < RD_LAT; s++) begin
        rd_vld_p[s] <= rd_vld_p[s-1];
        rd_tag_p[s] <= rd_tag_p[s-1];
      end
    end
  end

  // Return stage: register the read data and strobe the tagged requester.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_valid <= '0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= rd_vld_p[RD_LAT-1] ? to_onehot(rd_tag_p[RD_LAT-1]) : '0;
      if (rd_vld_p[RD_LAT-1]) o_rd_data <= i_ram_dout;
    end
  end

endmodule

// File: tb/tb_xintf_ram_arbiter.sv
module tb_xintf_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        model_init;
  logic [1:0]  req_r, we_r;
  logic [8:0]  addr_r [2];
  logic [15:0] din_r  [2];
  logic [1:0]  i_req, i_we;
  logic [17:0] i_addr;
  logic [31:0] i_din;
  logic [1:0]  gnt, rd_valid, owner;
  logic [8:0]  ram_addr;
  logic [15:0] ram_din, ram_dout, rd_data;
  logic        ram_ce, ram_we, busy;

  assign i_req  = req_r;
  assign i_we   = we_r;
  assign i_addr = {addr_r[1], addr_r[0]};
  assign i_din  = {din_r[1], din_r[0]};

  xintf_ram_arbiter #(
    .N_REQ(2), .ADDR_W(9), .DATA_W(16), .RD_LAT(1), .MAX_HOLD(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_din(i_din), .o_gnt(gnt),
    .o_ram_addr(ram_addr), .o_ram_din(ram_din), .o_ram_ce(ram_ce),
    .o_ram_we(ram_we), .i_ram_dout(ram_dout), .o_rd_data(rd_data),
    .o_rd_valid(rd_valid), .o_owner(owner), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with a read latency of one cycle. Addresses that were never
  // written read back 16'h5A00 ^ addr.
  logic [15:0]  mem [512];
  logic [511:0] touched;
  always @(posedge clk) begin
    if (model_init) touched <= '0;
    else if (ram_ce && ram_we) begin
      mem[ram_addr]     <= ram_din;
      touched[ram_addr] <= 1'b1;
    end
    if (ram_ce && !ram_we)
      ram_dout <= touched[ram_addr] ? mem[ram_addr] : (16'h5A00 ^ {7'd0, ram_addr});
  end

  typedef struct { int cyc; logic [1:0] ow; logic we; logic [8:0] a; logic [15:0] d; } acc_t;
  typedef struct { int cyc; logic [1:0] g; } gnt_t;
  typedef struct { int cyc; logic [1:0] v; logic [15:0] d; } rd_t;
  acc_t q_acc [$];
  gnt_t q_gnt [$];
  rd_t  q_rd  [$];

  int n_cmp;
  int n_fail;

  task automatic ea(input int c, input logic [1:0] ow, input logic we, input logic [8:0] a, input logic [15:0] d);
    acc_t e;
    e.cyc = c; e.ow = ow; e.we = we; e.a = a; e.d = d;
    q_acc.push_back(e);
  endtask

  task automatic eg(input int c, input logic [1:0] g);
    gnt_t e;
    e.cyc = c; e.g = g;
    q_gnt.push_back(e);
  endtask

  task automatic er(input int c, input logic [1:0] v, input logic [15:0] d);
    rd_t e;
    e.cyc = c; e.v = v; e.d = d;
    q_rd.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h need %0h", nm, act, exp);
    end
  endtask

  // Requester model: present the fields, advance them on each edge that
  // sees a grant, drop the request after n accesses, and stay idle for
  // one cycle afterwards.
  task automatic burst(input bit k, input bit we, input logic [8:0] a0,
                       input logic [15:0] d0, input logic [15:0] dstep, input int n);
    int  i;
    int  guard;
    bit  g;
    req_r[k] = 1'b1; we_r[k] = we; addr_r[k] = a0; din_r[k] = d0;
    i = 0; guard = 0;
    while (i < n && guard < 200) begin
      g = gnt[k];
      @(posedge clk); #1;
      guard++;
      if (g) begin
        i++;
        addr_r[k] = addr_r[k] + 9'd1;
        din_r[k]  = din_r[k] + dstep;
      end
    end
    n_cmp++;
    if (i != n) begin
      n_fail++;
      $display("FAIL burst_timeout req%0d: got %0d accesses need %0d", k, i, n);
    end
    req_r[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: pop from the queues and compare whenever the DUT presents an event.
  initial begin
    logic [1:0] prev_gnt;
    acc_t ae;
    gnt_t ge;
    rd_t  re;
    prev_gnt = 2'b00;
    forever begin
      @(negedge clk);
      n_cmp++;
      if (!$onehot0(gnt)) begin
        n_fail++;
        $display("FAIL gnt_onehot: got %b need one-hot or zero", gnt);
      end
      if (gnt !== prev_gnt) begin
        n_cmp++;
        if (q_gnt.size() == 0) begin
          n_fail++;
          $display("FAIL gnt_event: got gnt=%b at cyc %0d, need none", gnt, cyc);
        end else begin
          ge = q_gnt.pop_front();
          if (ge.cyc != cyc || ge.g !== gnt) begin
            n_fail++;
            $display("FAIL gnt_event: got gnt=%b cyc %0d need gnt=%b cyc %0d", gnt, cyc, ge.g, ge.cyc);
          end
        end
        prev_gnt = gnt;
      end
      if (ram_ce) begin
        n_cmp++;
        if (q_acc.size() == 0) begin
          n_fail++;
          $display("FAIL ram_access: got access addr %0h at cyc %0d, need none", ram_addr, cyc);
        end else begin
          ae = q_acc.pop_front();
          if (ae.cyc != cyc || ae.ow !== owner || ae.we !== ram_we || ae.a !== ram_addr || ae.d !== ram_din) begin
            n_fail++;
            $display("FAIL ram_access: got cyc %0d own %0d we %0d addr %0h din %0h need cyc %0d own %0d we %0d addr %0h din %0h",
                     cyc, owner, ram_we, ram_addr, ram_din, ae.cyc, ae.ow, ae.we, ae.a, ae.d);
          end
        end
      end
      if (rd_valid != 2'b00) begin
        n_cmp++;
        if (q_rd.size() == 0) begin
          n_fail++;
          $display("FAIL rd_return: got vld %b data %0h at cyc %0d, need none", rd_valid, rd_data, cyc);
        end else begin
          re = q_rd.pop_front();
          if (re.cyc != cyc || re.v !== rd_valid || re.d !== rd_data) begin
            n_fail++;
            $display("FAIL rd_return: got cyc %0d vld %b data %0h need cyc %0d vld %b data %0h",
                     cyc, rd_valid, rd_data, re.cyc, re.v, re.d);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1; model_init = 1'b1;
    req_r = '0; we_r = '0;
    addr_r[0] = '0; addr_r[1] = '0; din_r[0] = '0; din_r[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    model_init = 1'b0;
    chk("reset_gnt",   32'(gnt), 32'h0);
    chk("reset_ce",    32'(ram_ce), 32'h0);
    chk("reset_rdvld", 32'(rd_valid), 32'h0);
    chk("reset_owner", 32'(owner), 32'h0);
    chk("reset_busy",  32'(busy), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: req0 writes 3 words to 8..10
    t = cyc;
    eg(t+1, 2'b01); eg(t+5, 2'b00);
    ea(t+2, 0, 1, 9'd8,  16'h1111);
    ea(t+3, 0, 1, 9'd9,  16'h2222);
    ea(t+4, 0, 1, 9'd10, 16'h3333);
    burst(1'b0, 1'b1, 9'd8, 16'h1111, 16'h1111, 3);
    chk("t1_busy_release", 32'(busy), 32'h1);
    chk("t1_mem8",  32'(mem[8]),  32'h1111);
    chk("t1_mem9",  32'(mem[9]),  32'h2222);
    chk("t1_mem10", 32'(mem[10]), 32'h3333);
    repeat (3) @(posedge clk);
    #1;

    // 2: req1 reads 128 then 129
    t = cyc;
    eg(t+1, 2'b10); eg(t+4, 2'b00);
    ea(t+2, 1, 0, 9'd128, 16'h0);
    ea(t+3, 1, 0, 9'd129, 16'h0);
    er(t+4, 2'b10, 16'h5A80);
    er(t+5, 2'b10, 16'h5A81);
    burst(1'b1, 1'b0, 9'd128, 16'h0, 16'h0, 2);
    repeat (4) @(posedge clk);
    #1;

    // reset pulse so that requester 0 has priority again
    rst = 1'b1;
    #1;
    chk("rst2_owner", 32'(owner), 32'h0);
    chk("rst2_addr",  32'(ram_addr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 3: both requesters rise together; grants alternate 0,1,0,1
    t = cyc;
    eg(t+1, 2'b01); eg(t+4, 2'b00); eg(t+6, 2'b10); eg(t+9, 2'b00);
    eg(t+11, 2'b01); eg(t+14, 2'b00); eg(t+16, 2'b10); eg(t+19, 2'b00);
    ea(t+2,  0, 1, 9'd16, 16'hA000); ea(t+3,  0, 1, 9'd17, 16'hA001);
    ea(t+7,  1, 1, 9'd32, 16'hB000); ea(t+8,  1, 1, 9'd33, 16'hB001);
    ea(t+12, 0, 1, 9'd18, 16'hA002); ea(t+13, 0, 1, 9'd19, 16'hA003);
    ea(t+17, 1, 1, 9'd34, 16'hB002); ea(t+18, 1, 1, 9'd35, 16'hB003);
    fork
      begin
        burst(1'b0, 1'b1, 9'd16, 16'hA000, 16'h1, 2);
        burst(1'b0, 1'b1, 9'd18, 16'hA002, 16'h1, 2);
      end
      begin
        burst(1'b1, 1'b1, 9'd32, 16'hB000, 16'h1, 2);
        burst(1'b1, 1'b1, 9'd34, 16'hB002, 16'h1, 2);
      end
    join
    chk("t3_mem35", 32'(mem[35]), 32'hB003);
    repeat (3) @(posedge clk);
    #1;

    // 4a: MAX_HOLD=4, req0 wants 6 and req1 waits -> req0 is cut after 4 accesses
    t = cyc;
    eg(t+1, 2'b01); eg(t+5, 2'b00); eg(t+7, 2'b10); eg(t+10, 2'b00);
    eg(t+12, 2'b01); eg(t+15, 2'b00);
    ea(t+2, 0, 1, 9'd40, 16'hC000); ea(t+3, 0, 1, 9'd41, 16'hC001);
    ea(t+4, 0, 1, 9'd42, 16'hC002); ea(t+5, 0, 1, 9'd43, 16'hC003);
    ea(t+8, 1, 1, 9'd48, 16'hD000); ea(t+9, 1, 1, 9'd49, 16'hD001);
    ea(t+13, 0, 1, 9'd44, 16'hC004); ea(t+14, 0, 1, 9'd45, 16'hC005);
    fork
      burst(1'b0, 1'b1, 9'd40, 16'hC000, 16'h1, 6);
      burst(1'b1, 1'b1, 9'd48, 16'hD000, 16'h1, 2);
    join
    chk("t4_mem45", 32'(mem[45]), 32'hC005);
    repeat (3) @(posedge clk);
    #1;

    // 4b: req0 alone keeps the grant for 7 accesses
    t = cyc;
    eg(t+1, 2'b01); eg(t+9, 2'b00);
    for (int i = 0; i < 7; i++)
      ea(t+2+i, 0, 1, 9'(56+i), 16'hE000 + 16'(i));
    burst(1'b0, 1'b1, 9'd56, 16'hE000, 16'h1, 7);
    chk("t4b_mem62", 32'(mem[62]), 32'hE006);
    repeat (3) @(posedge clk);
    #1;

    // 5: req0 reads in the last cycle of its grant, then req1 is granted
    t = cyc;
    eg(t+1, 2'b01); eg(t+3, 2'b00); eg(t+5, 2'b10); eg(t+7, 2'b00);
    ea(t+2, 0, 0, 9'd130, 16'h0);
    ea(t+6, 1, 0, 9'd131, 16'h0);
    er(t+4, 2'b01, 16'h5A82);
    er(t+8, 2'b10, 16'h5A83);
    fork
      burst(1'b0, 1'b0, 9'd130, 16'h0, 16'h0, 1);
      begin
        @(posedge clk); #1;
        burst(1'b1, 1'b0, 9'd131, 16'h0, 16'h0, 1);
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // 6: reset while two reads are in flight
    t = cyc;
    eg(t+1, 2'b10); eg(t+4, 2'b00);
    ea(t+2, 1, 0, 9'd132, 16'h0);
    ea(t+3, 1, 0, 9'd132, 16'h0);
    req_r[1] = 1'b1; we_r[1] = 1'b0; addr_r[1] = 9'd132; din_r[1] = 16'h0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #6;
    rst = 1'b1;
    req_r[1] = 1'b0;
    #1;
    chk("rst6_gnt",   32'(gnt), 32'h0);
    chk("rst6_ce",    32'(ram_ce), 32'h0);
    chk("rst6_rdvld", 32'(rd_valid), 32'h0);
    chk("rst6_busy",  32'(busy), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst6_rdvld_after", 32'(rd_valid), 32'h0);
    t = cyc;
    eg(t+1, 2'b01); eg(t+3, 2'b00); eg(t+5, 2'b10); eg(t+7, 2'b00);
    ea(t+2, 0, 1, 9'd70, 16'h7070);
    ea(t+6, 1, 1, 9'd71, 16'h7171);
    fork
      burst(1'b0, 1'b1, 9'd70, 16'h7070, 16'h0, 1);
      burst(1'b1, 1'b1, 9'd71, 16'h7171, 16'h0, 1);
    join
    repeat (5) @(posedge clk);
    #1;

    chk("left_acc", 32'(q_acc.size()), 32'h0);
    chk("left_gnt", 32'(q_gnt.size()), 32'h0);
    chk("left_rd",  32'(q_rd.size()),  32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
